// File: rtl/cache_pkg.sv
// Shared types for the cache memory-side bridge: FSM states, line geometry
// and the write-buffer entry layout.
package cache_pkg;

    // A cache line is fetched as this many 16-bit SDRAM beats.
    localparam int LINE_BEATS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_DATA,
        ACK
    } bridge_state_t;

    // One queued CPU write: word address, data and byte selects (48 bits).
    typedef struct packed {
        logic [30:1] adr;
        logic [15:0] dat;
        logic [1:0]  bs;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for queued CPU writes. Pointers carry one extra
// wrap bit so that full and empty can be told apart with equal indices.
// A push while full is accepted only if a pop happens in the same cycle.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted pop/push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cache_sdram_bridge.sv
// Memory-side responder for the write-through cache. Queues write strobes,
// drains them to the SDRAM command port, and serves line fills as 4-beat
// burst reads assembled into a 64-bit line. Writes always drain before a
// fill is issued so a fill sees every earlier write.
module cache_sdram_bridge
    import cache_pkg::*;
#(
    parameter int WBDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:1] cpu_adr,
    input  logic [15:0] cpu_dat_w,
    input  logic [1:0]  cpu_bs,
    input  logic        mem_read_req,
    output logic [63:0] mem_dat_r,
    output logic        mem_read_ack,
    input  logic        wb_en,
    output logic        wb_full,
    output logic        wb_ovf,
    output logic        sd_req,
    output logic        sd_we,
    output logic [30:1] sd_adr,
    output logic [1:0]  sd_bs,
    output logic [15:0] sd_dat_w,
    input  logic        sd_ack,
    input  logic        sd_rdv,
    input  logic [15:0] sd_dat_r
);
    localparam int            CW        = $clog2(LINE_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    bridge_state_t state, state_n;
    logic          wb_en_q;
    logic          push, pop;
    logic          fifo_empty, fifo_full;
    wb_entry_t     in_entry, head_entry;
    logic          pending;
    logic [30:3]   line_q, rd_line;
    logic [CW-1:0] beat_cnt;
    logic          ld_wr, wr_from_head, ld_rd, beat_we, fill_done;

    assign push      = wb_en & ~wb_en_q;
    assign in_entry  = {cpu_adr, cpu_dat_w, cpu_bs};
    assign rd_line   = pending ? line_q : cpu_adr[30:3];
    assign sd_req    = (state == WR_CMD) || (state == RD_CMD);
    assign mem_read_ack = (state == ACK);
    assign wb_full   = fifo_full;

    wb_fifo #(
        .DEPTH (WBDEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .head  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and command/beat strobes; a strobe arriving at an idle,
    // empty bridge is issued straight from the CPU inputs.
    always_comb begin
        state_n      = state;
        ld_wr        = 1'b0;
        wr_from_head = 1'b0;
        ld_rd        = 1'b0;
        pop          = 1'b0;
        beat_we      = 1'b0;
        fill_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n      = WR_CMD;
                    ld_wr        = 1'b1;
                    wr_from_head = 1'b1;
                end else if (push) begin
                    state_n = WR_CMD;
                    ld_wr   = 1'b1;
                end else if (pending || mem_read_req) begin
                    state_n = RD_CMD;
                    ld_rd   = 1'b1;
                end
            end
            WR_CMD: begin
                if (sd_ack) begin
                    pop     = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_CMD: begin
                if (sd_ack) begin
                    state_n = RD_DATA;
                    beat_we = sd_rdv;
                end
            end
            RD_DATA: begin
                beat_we = sd_rdv;
                if (sd_rdv && beat_cnt == LAST_BEAT) state_n = ACK;
            end
            ACK: begin
                fill_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // SDRAM command fields, loaded once per command and held while sd_req is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_we    <= 1'b0;
            sd_adr   <= '0;
            sd_bs    <= 2'b11;
            sd_dat_w <= '0;
        end else if (ld_wr) begin
            sd_we <= 1'b1;
            if (wr_from_head) {sd_adr, sd_dat_w, sd_bs} <= head_entry;
            else              {sd_adr, sd_dat_w, sd_bs} <= in_entry;
        end else if (ld_rd) begin
            sd_we  <= 1'b0;
            sd_adr <= {rd_line, 2'b00};
        end
    end

    // Fill request latch: one outstanding line, released by the acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            line_q  <= '0;
        end else if (fill_done) begin
            pending <= 1'b0;
        end else if (mem_read_req && !pending) begin
            pending <= 1'b1;
            line_q  <= cpu_adr[30:3];
        end
    end

    // Beat counter and lane assembly of the returned line.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            mem_dat_r <= '0;
        end else begin
            if (ld_rd)        beat_cnt <= '0;
            else if (beat_we) beat_cnt <= beat_cnt + CNT_ONE;
            if (beat_we) mem_dat_r[16*beat_cnt +: 16] <= sd_dat_r;
        end
    end

    // Strobe edge detect and sticky overflow on a dropped push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q <= 1'b0;
            wb_ovf  <= 1'b0;
        end else begin
            wb_en_q <= wb_en;
            if (push && fifo_full && !pop) wb_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_sdram_bridge.sv
// Bench for cache_sdram_bridge: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the bridge.
module tb_cache_sdram_bridge;
    localparam int WBDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:1] cpu_adr;
    logic [15:0] cpu_dat_w;
    logic [1:0]  cpu_bs;
    logic        mem_read_req;
    logic [63:0] mem_dat_r;
    logic        mem_read_ack;
    logic        wb_en;
    logic        wb_full;
    logic        wb_ovf;
    logic        sd_req;
    logic        sd_we;
    logic [30:1] sd_adr;
    logic [1:0]  sd_bs;
    logic [15:0] sd_dat_w;
    logic        sd_ack;
    logic        sd_rdv;
    logic [15:0] sd_dat_r;

    always #5 clk = ~clk;

    cache_sdram_bridge #(.WBDEPTH(WBDEPTH)) dut (
        .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_dat_w(cpu_dat_w), .cpu_bs(cpu_bs),
        .mem_read_req(mem_read_req), .mem_dat_r(mem_dat_r), .mem_read_ack(mem_read_ack),
        .wb_en(wb_en), .wb_full(wb_full), .wb_ovf(wb_ovf),
        .sd_req(sd_req), .sd_we(sd_we), .sd_adr(sd_adr), .sd_bs(sd_bs), .sd_dat_w(sd_dat_w),
        .sd_ack(sd_ack), .sd_rdv(sd_rdv), .sd_dat_r(sd_dat_r)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [47:0] mq[$];       // writes accepted and not yet acknowledged, oldest first
    bit          m_ovf, m_wb_prev, m_pend, m_fill_act, m_ack_due, m_req_prev, m_we_prev;
    logic [30:3] m_line;
    int          m_beats;
    logic [63:0] m_data;
    logic [47:0] m_cmd_prev;

    // Compare outputs against the model, then advance the model by this cycle's inputs.
    always @(negedge clk) begin : model_proc
        bit pop_e, push_e, full_b;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_wb_prev = 0; m_pend = 0; m_fill_act = 0; m_ack_due = 0;
            m_req_prev = 0; m_we_prev = 0; m_beats = 0; m_data = '0; m_line = '0; m_cmd_prev = '0;
        end else begin
            check("wb_full", wb_full, mq.size() == WBDEPTH);
            check("wb_ovf", wb_ovf, m_ovf);
            check("mem_read_ack", mem_read_ack, m_ack_due);
            check("mem_dat_r", mem_dat_r, m_data);
            if (sd_req && m_req_prev)
                check("sd_stable", {sd_we, sd_adr, sd_dat_w, sd_bs}, {m_we_prev, m_cmd_prev});
            if (sd_req && !m_req_prev) begin
                if (sd_we) begin
                    check("wr_has_entry", mq.size() != 0, 1);
                    if (mq.size() != 0) check("wr_cmd", {sd_adr, sd_dat_w, sd_bs}, mq[0]);
                end else begin
                    check("rd_after_writes", mq.size(), 0);
                    check("rd_pending", m_pend && !m_fill_act, 1);
                    check("rd_adr", sd_adr, {m_line, 2'b00});
                end
            end
            m_req_prev = sd_req;
            m_we_prev  = sd_we;
            m_cmd_prev = {sd_adr, sd_dat_w, sd_bs};
            pop_e  = sd_req && sd_ack && sd_we;
            push_e = wb_en && !m_wb_prev;
            m_wb_prev = wb_en;
            full_b = (mq.size() == WBDEPTH);
            if (pop_e && mq.size() != 0) void'(mq.pop_front());
            if (push_e) begin
                if (full_b && !pop_e) m_ovf = 1;
                else mq.push_back({cpu_adr, cpu_dat_w, cpu_bs});
            end
            if (mem_read_req && !m_pend) begin
                m_pend = 1;
                m_line = cpu_adr[30:3];
            end
            if (m_ack_due) m_pend = 0;
            m_ack_due = 0;
            if (sd_req && sd_ack && !sd_we) begin
                m_fill_act = 1;
                m_beats = 0;
            end
            if (m_fill_act && sd_rdv) begin
                m_data[16*m_beats +: 16] = sd_dat_r;
                m_beats++;
                if (m_beats == 4) begin
                    m_fill_act = 0;
                    m_ack_due = 1;
                end
            end
        end
    end

    // ---------------- stimulus and SDRAM responder ----------------
    bit auto_en;
    int ack_p;
    int beats_left;

    task automatic tick();
        @(posedge clk); #1;
        if (auto_en) begin
            sd_ack = 0;
            sd_rdv = 0;
            if (sd_req && $urandom_range(99) < ack_p) begin
                sd_ack = 1;
                if (!sd_we) beats_left = 4;
            end
            if (beats_left > 0 && $urandom_range(99) < 50) begin
                sd_rdv = 1; sd_dat_r = 16'($urandom); beats_left--;
            end else if (beats_left == 0 && !sd_req && $urandom_range(99) < 5) begin
                sd_rdv = 1; sd_dat_r = 16'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic req_fill(input logic [30:1] adr);
        cpu_adr = adr; mem_read_req = 1; tick(); mem_read_req = 0;
    endtask

    // Accept the read command and return the given line as 4 beats, gap idle cycles between beats.
    task automatic serve_fill(input logic [63:0] line, input int gap, input string tag);
        int waitc = 0;
        while (!(sd_req && !sd_we) && waitc < 50) begin tick(); waitc++; end
        if (waitc >= 50) begin check({tag, "_rd_timeout"}, 0, 1); return; end
        sd_ack = 1;
        for (int b = 0; b < 4; b++) begin
            if (gap > 0) begin
                sd_rdv = 0; tick(); sd_ack = 0;
                check({tag, "_no_early_ack"}, mem_read_ack, 0);
                for (int g = 1; g < gap; g++) begin
                    tick();
                    check({tag, "_no_early_ack"}, mem_read_ack, 0);
                end
            end
            sd_rdv = 1; sd_dat_r = line[16*b +: 16];
            tick(); sd_ack = 0; sd_rdv = 0;
        end
        check({tag, "_ack"}, mem_read_ack, 1);
        check({tag, "_line"}, mem_dat_r, line);
        tick();
        check({tag, "_ack_single"}, mem_read_ack, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        int waitc;
        logic [15:0] got[$];
        rst = 1; wb_en = 0; mem_read_req = 0; cpu_adr = '0; cpu_dat_w = '0; cpu_bs = '0;
        sd_ack = 0; sd_rdv = 0; sd_dat_r = '0; auto_en = 0; ack_p = 40; beats_left = 0;
        idle(3);
        rst = 0;
        check("rst_sd_req", sd_req, 0);
        check("rst_sd_we", sd_we, 0);
        check("rst_sd_adr", sd_adr, 0);
        check("rst_sd_bs", sd_bs, 2'b11);
        check("rst_sd_dat_w", sd_dat_w, 0);
        check("rst_ack", mem_read_ack, 0);
        check("rst_dat", mem_dat_r, 0);
        check("rst_full", wb_full, 0);
        check("rst_ovf", wb_ovf, 0);
        idle(2);

        // Aligned fill, beat 0 with the command accept.
        req_fill(30'h100);
        check("aligned_req_latency", sd_req, 1);
        check("aligned_we", sd_we, 0);
        check("aligned_adr", sd_adr, 30'h100);
        serve_fill(64'h4444_3333_2222_1111, 0, "aligned");
        idle(2);

        // Unaligned fill with 3-cycle beat gaps.
        req_fill(30'h103);
        check("unaligned_adr", sd_adr, 30'h100);
        serve_fill(64'h4444_3333_2222_1111, 3, "gaps");
        idle(2);

        // Write then read: the write goes out first.
        cpu_adr = 30'h200; cpu_dat_w = 16'hABCD; cpu_bs = 2'b01; wb_en = 1;
        tick();
        wb_en = 0;
        check("raw_wr_req", sd_req, 1);
        check("raw_wr_we", sd_we, 1);
        check("raw_wr_adr", sd_adr, 30'h200);
        check("raw_wr_bs", sd_bs, 2'b01);
        check("raw_wr_dat", sd_dat_w, 16'hABCD);
        req_fill(30'h300);
        check("raw_hold_we", {sd_req, sd_we}, 2'b11);
        tick();
        check("raw_hold_we2", {sd_req, sd_we}, 2'b11);
        sd_ack = 1; tick(); sd_ack = 0;
        check("raw_req_drop", sd_req, 0);
        tick();
        check("raw_rd_req", {sd_req, sd_we}, 2'b10);
        check("raw_rd_adr", sd_adr, 30'h300);
        serve_fill(64'h0123_4567_89AB_CDEF, 0, "raw");
        idle(2);

        // Held strobe pushes once.
        cpu_adr = 30'h40; cpu_dat_w = 16'h5555; cpu_bs = 2'b11; wb_en = 1;
        idle(5);
        wb_en = 0;
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            sd_ack = sd_req;
            if (sd_ack) nwr++;
            tick(); sd_ack = 0;
        end
        check("held_one_write", nwr, 1);

        // Overflow with the command port stalled.
        for (int i = 1; i <= 5; i++) begin
            cpu_adr = 30'(32'h10 + i); cpu_dat_w = 16'(i); cpu_bs = 2'b11; wb_en = 1;
            tick();
            wb_en = 0;
            if (i == 4) begin
                check("ovf_full4", wb_full, 1);
                check("ovf_none4", wb_ovf, 0);
            end
            if (i == 5) check("ovf_set5", wb_ovf, 1);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            sd_ack = sd_req;
            if (sd_ack) got.push_back(sd_dat_w);
            tick(); sd_ack = 0;
        end
        check("ovf_drain_count", got.size(), 4);
        for (int k = 0; k < got.size() && k < 4; k++) check("ovf_drain_order", got[k], k + 1);
        check("ovf_sticky", wb_ovf, 1);

        // Reset in the middle of a burst.
        req_fill(30'h180);
        sd_ack = 1; sd_rdv = 1; sd_dat_r = 16'hAAAA; tick();
        sd_ack = 0; sd_dat_r = 16'hBBBB; tick();
        sd_rdv = 0; rst = 1; tick(); rst = 0;
        check("mrst_sd_req", sd_req, 0);
        check("mrst_ack", mem_read_ack, 0);
        check("mrst_dat", mem_dat_r, 0);
        check("mrst_ovf", wb_ovf, 0);
        check("mrst_bs", sd_bs, 2'b11);
        for (int i = 0; i < 3; i++) begin
            sd_rdv = 1; sd_dat_r = 16'hDEAD; tick();
            check("stray_ack", mem_read_ack, 0);
            check("stray_dat", mem_dat_r, 0);
        end
        sd_rdv = 0;
        req_fill(30'h180);
        check("post_rst_adr", sd_adr, 30'h180);
        serve_fill(64'hFEDC_BA98_7654_3210, 1, "post_rst");
        idle(2);

        // Randomized traffic against the model.
        auto_en = 1; beats_left = 0; ack_p = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 250) ack_p = 3;
            if (c % 500 == 350) ack_p = 40;
            if ($urandom_range(99) < 35) wb_en = ~wb_en;
            cpu_adr = 30'($urandom); cpu_dat_w = 16'($urandom); cpu_bs = 2'($urandom);
            mem_read_req = !m_pend && ($urandom_range(99) < 10);
            rst = ($urandom_range(999) == 0);
            if (rst) beats_left = 0;
            tick();
        end
        rst = 0; mem_read_req = 0; ack_p = 50;
        waitc = 0;
        while (!(mq.size() == 0 && !m_pend && !m_fill_act && !m_ack_due && !sd_req) && waitc < 1000) begin
            tick(); waitc++;
        end
        check("drain_done", waitc < 1000, 1);
        auto_en = 0; sd_ack = 0; sd_rdv = 0;
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_sdram_bridge.md
# cache_sdram_bridge

Memory-side responder for the 2-way write-through CPU cache. It accepts the cache's line-fill request and its write-buffer strobe. Writes are queued in a small FIFO and drained to a 16-bit SDRAM controller port. Each fill is a 4-beat burst read, assembled into the 64-bit line the cache expects, and completed with a single-cycle acknowledge.

## Interface
- `WBDEPTH`, 4: write-buffer entries, power of two, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_adr` in 30 ([30:1]): CPU word address; sampled for both fills and writes.
- `cpu_dat_w` in 16: CPU write data.
- `cpu_bs` in 2: CPU byte selects.
- `mem_read_req` in 1: single-cycle fill request from the cache.
- `mem_dat_r` out 64: assembled line; beat k occupies `[16k+15:16k]`.
- `mem_read_ack` out 1: single-cycle fill-complete pulse.
- `wb_en` in 1: write strobe, level, may be held for many cycles.
- `wb_full` out 1: FIFO holds `WBDEPTH` entries.
- `wb_ovf` out 1: sticky overflow flag; cleared only by `rst`.
- `sd_req` out 1: command request to the SDRAM controller.
- `sd_we` out 1: 1 = single-word write, 0 = 4-beat burst read.
- `sd_adr` out 30 ([30:1]): command word address.
- `sd_bs` out 2: write byte enables.
- `sd_dat_w` out 16: write data.
- `sd_ack` in 1: single-cycle command accept.
- `sd_rdv` in 1: read beat valid.
- `sd_dat_r` in 16: read beat data.

## Operation
- **Write capture**
  - One FIFO push per rising edge of `wb_en` (`wb_en & ~wb_en_q`).
  - Pushes `{cpu_adr, cpu_dat_w, cpu_bs}` as sampled in the edge cycle.
  - A held `wb_en` never pushes twice.
- **Overflow**
  - A push while full drops the entry and sets `wb_ovf`.
  - Existing entries are unaffected.
  - A push and a pop in the same cycle while full is legal and loses nothing.
- **Fill capture**
  - On `mem_read_req` the line address `cpu_adr[30:3]` is latched and a pending flag is set.
  - A second request while pending or busy is ignored; the cache never issues one.
- **Ordering**
  - Writes drain before a pending fill is issued: a read is issued only when the FIFO is empty.
  - This gives read-after-write coherency.
  - Write edges arriving during a read are queued and drained after the fill acknowledge.
- **FSM states**
  - IDLE
    - FIFO non-empty → WR_CMD, with the head entry loaded onto the `sd_*` outputs.
    - Otherwise, fill pending → RD_CMD, with `sd_adr = {line,2'b00}` and `sd_we = 0`.
  - WR_CMD
    - `sd_req` is held until `sd_ack`.
    - On `sd_ack`: pop the FIFO and return to IDLE.
  - RD_CMD
    - `sd_req` is held until `sd_ack`, then → RD_DATA with beat counter = 0.
  - RD_DATA
    - Each `sd_rdv` writes `sd_dat_r` into lane [counter] and increments the 2-bit counter.
    - `sd_rdv` in the same cycle as `sd_ack` counts as beat 0.
    - The 4th beat (counter wraps 3→0) → ACK.
  - ACK
    - Pulse `mem_read_ack` for one cycle, clear the pending flag, → IDLE.
- **Gaps**: beats may be non-consecutive; gaps are unbounded.
- **Stray beats**: `sd_rdv` outside RD_DATA is ignored.
- **Output stability**
  - `sd_adr`, `sd_we`, `sd_bs` and `sd_dat_w` are stable for the whole time `sd_req` is high.
  - `mem_dat_r` holds its value from ACK until the first beat of the next fill.

## Timing
- **Reset values**
  - `mem_read_ack` = 0, `mem_dat_r` = 0.
  - `sd_req` = 0, `sd_we` = 0, `sd_adr` = 0, `sd_bs` = 2'b11, `sd_dat_w` = 0.
  - `wb_full` = 0, `wb_ovf` = 0.
  - FIFO empty, pending flag cleared, FSM in IDLE.
- **Reset mid-operation**
  - Aborts any command or burst; no `mem_read_ack` is generated.
  - `sd_req` is 0 in the cycle after `rst` is sampled.
- **Write latency**: `wb_en` edge at cycle n → `sd_req` high at n+1 at the earliest, if IDLE and the FIFO was empty.
- **Fill latency**
  - `mem_read_req` at cycle n with the FIFO empty → `sd_req` at n+1.
  - `mem_read_ack` is high exactly in the cycle after the cycle of the 4th `sd_rdv`.
- **`sd_req` de-assertion**: `sd_req` falls in the cycle after `sd_ack`.
- **Back-to-back commands**: a following command may raise `sd_req` one cycle later at the earliest (IDLE cycle between commands).
- **`wb_full`**: registered, reflects the FIFO count after the current cycle's push/pop.

## Structure
- Shared package `cache_pkg`:
  - FSM state enum (IDLE, WR_CMD, RD_CMD, RD_DATA, ACK).
  - `LINE_BEATS` = 4.
  - Write-entry struct: adr[30:1], dat[15:0], bs[1:0], 48 bits total.
- Sub-module `wb_fifo`:
  - Synchronous FIFO parameterised by depth and width.
  - Provides push, pop, head, full and empty.
  - Read pointer and write pointer each one bit wider than the index, for the full/empty distinction.
- FSM, fill latch, lane assembly and edge detect live in the top level.

## Test plan
- **Aligned fill**: fill at `cpu_adr` 0x100; beats 0x1111, 0x2222, 0x3333, 0x4444 → `sd_adr` = 0x100 with `sd_we` = 0; `mem_dat_r` = 0x4444_3333_2222_1111; a single `mem_read_ack` in the cycle after the 4th beat.
- **Unaligned fill with gaps**: fill at `cpu_adr` 0x103 with 3-cycle gaps between beats → `sd_adr` = 0x100; identical lane placement; no early ack.
- **Write then read**: `wb_en` edge at adr 0x200, data 0xABCD, `bs` 01, then a fill request 1 cycle later → write command (`sd_we` = 1, `sd_bs` = 01) is issued first; the read `sd_req` rises only after the write's `sd_ack`.
- **Held strobe**: `wb_en` held 5 cycles → exactly one FIFO entry and one write command.
- **Overflow**: `sd_ack` held low; 5 `wb_en` edges with data 1..5 → `wb_full` = 1 after the 4th; `wb_ovf` = 1 after the 5th; `sd_ack` then released → writes 1..4 drain in order and data 5 is never issued.
- **Reset mid-burst**: `rst` asserted after 2 beats of a fill → all outputs take reset values; no ack; later stray `sd_rdv` ignored; a following fill completes normally.
